// File: rtl/msrh_pkg.sv
// Shared types and helpers for the done-report arbiter: report payload, commit-ID age compare.
package msrh_pkg;

  localparam int unsigned CMT_ID_W       = 6;
  localparam int unsigned GRP_ID_W       = 4;
  localparam int unsigned EXC_W          = 5;
  localparam int unsigned DONE_ARB_DEPTH = 4;

  typedef logic [CMT_ID_W-1:0] cmt_id_t;

  typedef struct packed {
    cmt_id_t             cmt_id;
    logic [GRP_ID_W-1:0] grp_id;
    logic [EXC_W-1:0]    exc;
  } done_rpt_t;

  // True when a is younger than b; the MSB is the ROB wrap bit.
  function automatic logic id0_is_younger(cmt_id_t a, cmt_id_t b);
    logic [CMT_ID_W-2:0] a_idx;
    logic [CMT_ID_W-2:0] b_idx;
    a_idx = a[CMT_ID_W-2:0];
    b_idx = b[CMT_ID_W-2:0];
    if (a[CMT_ID_W-1] != b[CMT_ID_W-1]) return a_idx < b_idx;
    return a_idx > b_idx;
  endfunction

endpackage

// File: rtl/msrh_done_rpt_fifo.sv
// Per-source done-report FIFO with a valid bit per entry so flushes can kill entries in place.
// Optional MSRH_DONE_ARB_PERF_EN exports the per-cycle flush-kill count.
module msrh_done_rpt_fifo
  import msrh_pkg::*;
#(
  parameter int unsigned DEPTH = DONE_ARB_DEPTH
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_push,
  input  done_rpt_t i_push_data,
  input  logic      i_pop,
  input  logic      i_flush_valid,
  input  cmt_id_t   i_flush_cmt_id,
  output done_rpt_t o_head_data,
  output logic      o_head_live_c,
  output logic      o_ovf_c,
`ifdef MSRH_DONE_ARB_PERF_EN
  output logic [$clog2(DEPTH+2)-1:0] o_kill_cnt_c,
`endif
  output logic      o_almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned KW    = $clog2(DEPTH+2);

  done_rpt_t        mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             afull_q;
  logic [DEPTH-1:0] kill_c;
  logic             empty_c, full_c, push_kill_c, push_c, pop_c;

  // Flush kills: buffered entries and the incoming push, when younger than the flush ID.
  always_comb begin : flush_kill
    kill_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_c[i] = i_flush_valid & vld_q[i] & id0_is_younger(mem_q[i].cmt_id, i_flush_cmt_id);
    end
    push_kill_c = i_flush_valid & id0_is_younger(i_push_data.cmt_id, i_flush_cmt_id);
  end

  always_comb begin : ctrl
    empty_c       = (cnt_q == '0);
    full_c        = (cnt_q == CNT_W'(DEPTH));
    o_head_data   = mem_q[rd_q];
    o_head_live_c = !empty_c & vld_q[rd_q] & !kill_c[rd_q];
    // A dead head leaves on its own, one per cycle.
    pop_c         = !empty_c & (i_pop | !o_head_live_c);
    push_c        = i_push & !push_kill_c & !full_c;
    o_ovf_c       = i_push & !push_kill_c & full_c;
  end

  always_comb begin : next_state
    vld_d = vld_q & ~kill_c;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (pop_c) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PTR_W'(1);
    end
    if (push_c) begin
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      afull_q <= 1'b0;
    end else begin
      if (push_c) mem_q[wr_q] <= i_push_data;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      afull_q <= (cnt_d >= CNT_W'(DEPTH-1));
    end
  end

  assign o_almost_full = afull_q;

`ifdef MSRH_DONE_ARB_PERF_EN
  always_comb begin : kill_count
    o_kill_cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) o_kill_cnt_c = o_kill_cnt_c + KW'(kill_c[i]);
    o_kill_cnt_c = o_kill_cnt_c + KW'(i_push & push_kill_c);
  end
`endif

endmodule

// File: rtl/msrh_done_rpt_arb.sv
// Round-robin arbiter merging per-source done reports into one registered ROB port.
// Optional MSRH_DONE_ARB_PERF_EN adds stall-cycle and flush-drop performance counters.
module msrh_done_rpt_arb
  import msrh_pkg::*;
#(
  parameter int unsigned SRC_NUM = 2,
  parameter int unsigned DEPTH   = DONE_ARB_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [SRC_NUM-1:0]           i_src_valid,
  input  logic [SRC_NUM*CMT_ID_W-1:0]  i_src_cmt_id,
  input  logic [SRC_NUM*GRP_ID_W-1:0]  i_src_grp_id,
  input  logic [SRC_NUM*EXC_W-1:0]     i_src_exc,
  output logic [SRC_NUM-1:0]           o_src_stall,
  input  logic                         i_flush_valid,
  input  logic [CMT_ID_W-1:0]          i_flush_cmt_id,
  output logic                         o_rob_valid,
  input  logic                         i_rob_ready,
  output logic [CMT_ID_W-1:0]          o_rob_cmt_id,
  output logic [GRP_ID_W-1:0]          o_rob_grp_id,
  output logic [EXC_W-1:0]             o_rob_exc,
  output logic [SRC_NUM-1:0]           o_src_sel,
`ifdef MSRH_DONE_ARB_PERF_EN
  output logic [31:0]                  o_perf_stall_cycles,
  output logic [15:0]                  o_perf_flush_drops,
`endif
  output logic                         o_overflow
);

  localparam int unsigned SEL_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int unsigned KW    = $clog2(DEPTH+2);

  done_rpt_t          src_rpt  [SRC_NUM];
  done_rpt_t          head_rpt [SRC_NUM];
  logic [SRC_NUM-1:0] head_live, pop_c, ovf_c;

  done_rpt_t          out_q, out_d;
  logic               out_vld_q, out_vld_d;
  logic [SRC_NUM-1:0] sel_q, sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic               ovf_q, ovf_d;

  logic               out_kill_c, load_en_c, grant_vld_c;
  logic [SEL_W-1:0]   grant_idx_c;

`ifdef MSRH_DONE_ARB_PERF_EN
  logic [KW-1:0]      fifo_kill [SRC_NUM];
`endif

  for (genvar g = 0; g < SRC_NUM; g++) begin : g_src
    assign src_rpt[g] = '{cmt_id: i_src_cmt_id[g*CMT_ID_W +: CMT_ID_W],
                          grp_id: i_src_grp_id[g*GRP_ID_W +: GRP_ID_W],
                          exc:    i_src_exc[g*EXC_W +: EXC_W]};

    msrh_done_rpt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_push         (i_src_valid[g]),
      .i_push_data    (src_rpt[g]),
      .i_pop          (pop_c[g]),
      .i_flush_valid  (i_flush_valid),
      .i_flush_cmt_id (i_flush_cmt_id),
      .o_head_data    (head_rpt[g]),
      .o_head_live_c  (head_live[g]),
      .o_ovf_c        (ovf_c[g]),
`ifdef MSRH_DONE_ARB_PERF_EN
      .o_kill_cnt_c   (fifo_kill[g]),
`endif
      .o_almost_full  (o_src_stall[g])
    );
  end

  // Round-robin grant, searching upward from rr_q with wrap.
  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    out_kill_c  = i_flush_valid & out_vld_q & id0_is_younger(out_q.cmt_id, i_flush_cmt_id);
    load_en_c   = !out_vld_q | i_rob_ready | out_kill_c;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 0; k < SRC_NUM; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= SRC_NUM) idx = idx - SRC_NUM;
      if (!grant_vld_c && load_en_c && head_live[SEL_W'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = SEL_W'(idx);
      end
    end
    pop_c = grant_vld_c ? (SRC_NUM'(1) << grant_idx_c) : '0;
  end

  always_comb begin : out_next
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    ovf_d     = ovf_q | (|ovf_c);
    if (grant_vld_c) begin
      out_d     = head_rpt[grant_idx_c];
      out_vld_d = 1'b1;
      sel_d     = pop_c;
      rr_d      = (grant_idx_c == SEL_W'(SRC_NUM-1)) ? '0 : grant_idx_c + SEL_W'(1);
    end else if (load_en_c) begin
      out_vld_d = 1'b0;
      sel_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sel_q     <= '0;
      rr_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_rob_valid  = out_vld_q;
  assign o_rob_cmt_id = out_q.cmt_id;
  assign o_rob_grp_id = out_q.grp_id;
  assign o_rob_exc    = out_q.exc;
  assign o_src_sel    = sel_q;
  assign o_overflow   = ovf_q;

`ifdef MSRH_DONE_ARB_PERF_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] drop_q, drop_d, drop_sum_c;
  logic [16:0] drop_acc_c;

  // Saturating counters for back-pressured cycles and flush-dropped reports.
  always_comb begin : perf_next
    drop_sum_c = 16'(out_kill_c);
    for (int i = 0; i < SRC_NUM; i++) drop_sum_c = drop_sum_c + 16'(fifo_kill[i]);
    drop_acc_c  = {1'b0, drop_q} + {1'b0, drop_sum_c};
    drop_d      = drop_acc_c[16] ? '1 : drop_acc_c[15:0];
    stall_cyc_d = stall_cyc_q;
    if (out_vld_q && !i_rob_ready && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cyc_q <= '0;
      drop_q      <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      drop_q      <= drop_d;
    end
  end

  assign o_perf_stall_cycles = stall_cyc_q;
  assign o_perf_flush_drops  = drop_q;
`endif

endmodule

// File: tb/tb_msrh_done_rpt_arb.sv
// Self-checking bench for msrh_done_rpt_arb against a queue-based reference model.
module tb_msrh_done_rpt_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_valid;
  logic [11:0] src_cmt;
  logic [7:0]  src_grp;
  logic [9:0]  src_exc;
  logic [1:0]  src_stall;
  logic        flush_valid;
  logic [5:0]  flush_id;
  logic        rob_valid, rob_ready;
  logic [5:0]  rob_cmt;
  logic [3:0]  rob_grp;
  logic [4:0]  rob_exc;
  logic [1:0]  src_sel;
  logic        overflow;
`ifdef MSRH_DONE_ARB_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_drops;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [5:0] cmt;
    logic [3:0] grp;
    logic [4:0] exc;
    bit         alive;
  } ent_t;

  ent_t       mq [2][$];
  bit         m_vld;
  ent_t       m_out;
  logic [1:0] m_sel;
  int         m_rr;
  bit         m_ovf;
  logic [1:0] m_stall;
  logic [5:0] acc_q [$];
  logic [1:0] acc_sel [$];

  msrh_done_rpt_arb dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_src_valid    (src_valid),
    .i_src_cmt_id   (src_cmt),
    .i_src_grp_id   (src_grp),
    .i_src_exc      (src_exc),
    .o_src_stall    (src_stall),
    .i_flush_valid  (flush_valid),
    .i_flush_cmt_id (flush_id),
    .o_rob_valid    (rob_valid),
    .i_rob_ready    (rob_ready),
    .o_rob_cmt_id   (rob_cmt),
    .o_rob_grp_id   (rob_grp),
    .o_rob_exc      (rob_exc),
    .o_src_sel      (src_sel),
`ifdef MSRH_DONE_ARB_PERF_EN
    .o_perf_stall_cycles (perf_stall),
    .o_perf_flush_drops  (perf_drops),
`endif
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Age rule: differing wrap bits invert the index ordering.
  function automatic bit younger(logic [5:0] a, logic [5:0] f);
    int ai = int'(a[4:0]);
    int fi = int'(f[4:0]);
    if (a[5] != f[5]) return ai < fi;
    return ai > fi;
  endfunction

  function automatic logic [20:0] observed();
    return {rob_valid, src_stall, overflow,
            rob_valid ? {rob_cmt, rob_grp, rob_exc, src_sel} : 17'h0};
  endfunction

  function automatic logic [20:0] expected();
    return {m_vld, m_stall, m_ovf,
            m_vld ? {m_out.cmt, m_out.grp, m_out.exc, m_sel} : 17'h0};
  endfunction

  task automatic m_reset();
    mq[0].delete(); mq[1].delete();
    m_vld = 0; m_out = '{default: '0}; m_sel = '0; m_rr = 0; m_ovf = 0; m_stall = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   kill_out, load;
    bit   pre_full [2];
    int   g;
    ent_t e;
    if (m_vld && rob_ready) begin
      acc_q.push_back(m_out.cmt);
      acc_sel.push_back(m_sel);
    end
    if (flush_valid)
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < mq[s].size(); i++)
          if (mq[s][i].alive && younger(mq[s][i].cmt, flush_id)) mq[s][i].alive = 0;
    kill_out = flush_valid && m_vld && younger(m_out.cmt, flush_id);
    load = !m_vld || rob_ready || kill_out;
    g = -1;
    if (load)
      for (int k = 0; k < 2; k++) begin
        int s = (m_rr + k) % 2;
        if (g < 0 && mq[s].size() > 0 && mq[s][0].alive) g = s;
      end
    for (int s = 0; s < 2; s++) begin
      pre_full[s] = (mq[s].size() == DEPTH);
      if (g == s) e = mq[s].pop_front();
      else if (mq[s].size() > 0 && !mq[s][0].alive) void'(mq[s].pop_front());
    end
    if (g >= 0) begin
      m_vld = 1; m_out = e; m_sel = 2'(1 << g); m_rr = (g + 1) % 2;
    end else if (load) begin
      m_vld = 0; m_sel = '0;
    end
    for (int s = 0; s < 2; s++) begin
      if (src_valid[s]) begin
        ent_t n;
        n.cmt = src_cmt[s*6 +: 6]; n.grp = src_grp[s*4 +: 4]; n.exc = src_exc[s*5 +: 5]; n.alive = 1;
        if (!(flush_valid && younger(n.cmt, flush_id))) begin
          if (pre_full[s]) m_ovf = 1;
          else mq[s].push_back(n);
        end
      end
      m_stall[s] = (mq[s].size() >= DEPTH - 1);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    src_valid   = '0;
    flush_valid = 1'b0;
  endtask

  task automatic set_src(int s, logic [5:0] c, logic [3:0] g, logic [4:0] e);
    src_valid[s]       = 1'b1;
    src_cmt[s*6 +: 6]  = c;
    src_grp[s*4 +: 4]  = g;
    src_exc[s*5 +: 5]  = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rob_valid, rob_cmt, rob_grp, rob_exc, src_sel, src_stall, overflow} !== 22'h0) begin
      fails++;
      $display("FAIL reset_state got %h required 0",
               {rob_valid, rob_cmt, rob_grp, rob_exc, src_sel, src_stall, overflow});
    end
    m_reset();
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rob_ready = 1'b1;
    set_src(0, 6'h05, 4'h1, 5'h0);
    tick();
    checks++;
    if (observed() !== expected()) begin
      fails++; $display("FAIL single_push got %h required %h", observed(), expected());
    end
    tick();
    checks++;
    if ({rob_valid, rob_cmt, rob_grp, rob_exc, src_sel} !== {1'b1, 6'h05, 4'h1, 5'h0, 2'b01}) begin
      fails++;
      $display("FAIL single_out got v=%b id=%h sel=%b required v=1 id=05 sel=01", rob_valid, rob_cmt, src_sel);
    end
    tick();
    checks++;
    if (observed() !== expected()) begin
      fails++; $display("FAIL single_drain got %h required %h", observed(), expected());
    end
  endtask

  task automatic test_fairness();
    acc_sel.delete(); acc_q.delete();
    rob_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c < 8) begin
        if (!src_stall[0]) set_src(0, 6'(c), 4'h2, 5'h0);
        if (!src_stall[1]) set_src(1, 6'(c + 16), 4'h4, 5'h1);
      end
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL fairness cyc %0d got %h required %h", c, observed(), expected());
      end
    end
    checks++;
    if (acc_sel.size() < 8) begin
      fails++; $display("FAIL fairness_count got %0d required >=8", acc_sel.size());
    end else
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (acc_sel[i] === acc_sel[i-1]) begin
          fails++; $display("FAIL fairness_alt idx %0d got %b required != %b", i, acc_sel[i], acc_sel[i-1]);
        end
      end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_ids [5];
    exp_ids = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14};
    acc_q.delete();
    rob_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_src(0, 6'(6'h10 + c), 4'h8, 5'(c));
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL backpressure push %0d got %h required %h", c, observed(), expected());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_set got %b required 1", overflow);
    end
    rob_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL backpressure drain %0d got %h required %h", c, observed(), expected());
      end
    end
    checks++;
    if (acc_q.size() != 5) begin
      fails++; $display("FAIL bp_order_len got %0d required 5", acc_q.size());
    end else
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acc_q[i] !== exp_ids[i]) begin
          fails++; $display("FAIL bp_order idx %0d got %h required %h", i, acc_q[i], exp_ids[i]);
        end
      end
  endtask

  // Buffer ids[0..2] on src0 with the ROB stalled, flush, then drain and compare survivors.
  task automatic run_flush(string name, logic [5:0] ids [3], logic [5:0] fid,
                           bit side_push, logic [5:0] side_id, logic [5:0] keep [2]);
    acc_q.delete();
    rob_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_src(0, ids[c], 4'h1, 5'h0);
      tick();
    end
    tick();
    flush_valid = 1'b1;
    flush_id    = fid;
    if (side_push) set_src(1, side_id, 4'h2, 5'h3);
    tick();
    checks++;
    if (observed() !== expected()) begin
      fails++; $display("FAIL %s flush_cycle got %h required %h", name, observed(), expected());
    end
    rob_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL %s drain %0d got %h required %h", name, c, observed(), expected());
      end
    end
    checks++;
    if (acc_q.size() != 2) begin
      fails++; $display("FAIL %s survivors got %0d required 2", name, acc_q.size());
    end else
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (acc_q[i] !== keep[i]) begin
          fails++; $display("FAIL %s survivor %0d got %h required %h", name, i, acc_q[i], keep[i]);
        end
      end
  endtask

  task automatic test_flush();
    run_flush("flush", '{6'h03, 6'h07, 6'h0A}, 6'h07, 1'b0, 6'h00, '{6'h03, 6'h07});
  endtask

  task automatic test_wrap_flush();
    run_flush("wrap", '{6'h1D, 6'h21, 6'h1E}, 6'h1E, 1'b1, 6'h22, '{6'h1D, 6'h1E});
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rob_ready = ($urandom_range(0, 9) < 7);
      for (int s = 0; s < 2; s++)
        if (!src_stall[s] && $urandom_range(0, 9) < 6)
          set_src(s, 6'($urandom), 4'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        flush_valid = 1'b1;
        flush_id    = 6'($urandom);
      end
      tick();
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL random cyc %0d got %h required %h", c, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_mid();
    rob_ready = 1'b0;
    set_src(0, 6'h01, 4'h1, 5'h0); set_src(1, 6'h02, 4'h2, 5'h0);
    tick();
    set_src(0, 6'h03, 4'h1, 5'h0); set_src(1, 6'h04, 4'h2, 5'h0);
    tick();
    checks++;
    if (rob_valid !== 1'b1) begin
      fails++; $display("FAIL mid_reset_setup got %b required 1", rob_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rob_valid, rob_cmt, rob_grp, rob_exc, src_sel, src_stall, overflow} !== 22'h0) begin
      fails++;
      $display("FAIL mid_reset_async got %h required 0",
               {rob_valid, rob_cmt, rob_grp, rob_exc, src_sel, src_stall, overflow});
    end
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    rob_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (rob_valid !== 1'b0 || observed() !== expected()) begin
        fails++; $display("FAIL mid_reset_stale cyc %0d got %h required %h", c, observed(), expected());
      end
    end
  endtask

  initial begin
    src_valid = '0; src_cmt = '0; src_grp = '0; src_exc = '0;
    flush_valid = 1'b0; flush_id = '0; rob_ready = 1'b0;
    acc_q.delete(); acc_sel.delete();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_flush();
    test_wrap_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
